// File: rtl/uba_npr_responder_pkg.sv
// Shared types and constants for the UBA NPR responder and its arbiter.
package ubanpr_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEM     = 2'd1,
    ACK     = 2'd2,
    RELEASE = 2'd3
  } state_e;

  localparam int AWID_DEF = 18;

  // Fixed FSM overhead when the memory answers; NXM paths add no time of their own.
  localparam int REQ_TO_MEMREQ_CLKS = 1;
  localparam int MIN_SVC_CLKS       = 2;

endpackage

// File: rtl/uba_npr_arb.sv
// Combinational NPR winner select; UBANPR_RR_EN selects round-robin from ptr+1,
// otherwise fixed priority with index 0 highest.
module uba_npr_arb #(
  parameter int NDEV = 4,
  parameter int IW   = 2
) (
  input  logic [NDEV-1:0] req,
`ifdef UBANPR_RR_EN
  input  logic [IW-1:0]   ptr,
`endif
  output logic [NDEV-1:0] gnt,
  output logic [IW-1:0]   idx
);

  always_comb begin
    gnt = '0;
    idx = '0;
`ifdef UBANPR_RR_EN
    // Walk the search order backwards so the entry nearest ptr+1 is written last and wins.
    for (int i = NDEV; i >= 1; i--) begin
      if (req[(int'(ptr) + i) % NDEV]) begin
        gnt = '0;
        gnt[(int'(ptr) + i) % NDEV] = 1'b1;
        idx = IW'((int'(ptr) + i) % NDEV);
      end
    end
`else
    for (int i = NDEV - 1; i >= 0; i--) begin
      if (req[i]) begin
        gnt    = '0;
        gnt[i] = 1'b1;
        idx    = IW'(i);
      end
    end
`endif
  end

endmodule

// File: rtl/uba_npr_responder.sv
// NPR responder: arbitrates device DMA requests, runs one memory cycle per grant, returns a 1-clk ACK.
// UBANPR_RR_EN enables round-robin arbitration; NXM cycles return no ACK so the requester times out.
module uba_npr_responder
  import ubanpr_pkg::*;
#(
  parameter int NDEV = 4,
  parameter int AWID = AWID_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NDEV-1:0]      devREQI,
  input  logic [NDEV*AWID-1:0] devADDRI,
  input  logic [NDEV-1:0]      devWRI,
  input  logic [NDEV-1:0]      devBYTEI,
  input  logic [NDEV*16-1:0]   devDATAI,
  output logic [NDEV-1:0]      devACKO,
  output logic [15:0]          devDATAO,
  output logic                 memREQ,
  output logic                 memWR,
  output logic                 memBYTE,
  output logic [AWID-1:0]      memADDR,
  output logic [15:0]          memDATAO,
  input  logic [15:0]          memDATAI,
  input  logic                 memACK,
  input  logic                 memNXM,
  output logic                 nprBUSY
);

  localparam int IW = (NDEV > 1) ? $clog2(NDEV) : 1;

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [AWID-1:0] addr_q, addr_d;
  logic            wr_q, wr_d;
  logic            byte_q, byte_d;
  logic            memreq_q, memreq_d;
  logic [15:0]     wdata_q, wdata_d;
  logic [15:0]     rdata_q, rdata_d;
  logic [NDEV-1:0] ack_q, ack_d;
  logic [NDEV-1:0] arb_gnt;
  logic [IW-1:0]   arb_idx;
`ifdef UBANPR_RR_EN
  logic [IW-1:0]   ptr_q, ptr_d;
`endif

  uba_npr_arb #(.NDEV(NDEV), .IW(IW)) u_arb (
    .req (devREQI),
`ifdef UBANPR_RR_EN
    .ptr (ptr_q),
`endif
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    addr_d   = addr_q;
    wr_d     = wr_q;
    byte_d   = byte_q;
    memreq_d = memreq_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    ack_d    = '0;
`ifdef UBANPR_RR_EN
    ptr_d    = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        // Qualifiers are captured only here; the master may change them freely afterwards.
        if (|arb_gnt) begin
          idx_d    = arb_idx;
          addr_d   = devADDRI[int'(arb_idx)*AWID +: AWID];
          wr_d     = devWRI[arb_idx];
          byte_d   = devBYTEI[arb_idx];
          wdata_d  = devDATAI[int'(arb_idx)*16 +: 16];
          memreq_d = 1'b1;
          state_d  = MEM;
`ifdef UBANPR_RR_EN
          ptr_d    = arb_idx;
`endif
        end
      end
      MEM: begin
        if (memNXM) begin
          memreq_d = 1'b0;
          state_d  = RELEASE;
        end else if (memACK) begin
          memreq_d = 1'b0;
          if (!wr_q) rdata_d = memDATAI;
          // A requester that already timed out gets no ACK for the late completion.
          if (devREQI[idx_q]) begin
            ack_d[idx_q] = 1'b1;
            state_d      = ACK;
          end else begin
            state_d = RELEASE;
          end
        end
      end
      ACK: state_d = RELEASE;
      RELEASE: begin
        if (!devREQI[idx_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      addr_q   <= '0;
      wr_q     <= 1'b0;
      byte_q   <= 1'b0;
      memreq_q <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      ack_q    <= '0;
`ifdef UBANPR_RR_EN
      ptr_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      addr_q   <= addr_d;
      wr_q     <= wr_d;
      byte_q   <= byte_d;
      memreq_q <= memreq_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      ack_q    <= ack_d;
`ifdef UBANPR_RR_EN
      ptr_q    <= ptr_d;
`endif
    end
  end

  assign devACKO  = ack_q;
  assign devDATAO = rdata_q;
  assign memREQ   = memreq_q;
  assign memWR    = memreq_q & wr_q;
  assign memBYTE  = memreq_q & byte_q;
  assign memADDR  = addr_q;
  assign memDATAO = wdata_q;
  assign nprBUSY  = (state_q != IDLE);

endmodule
